// File: rtl/fetch_decode_seq_pkg.sv
// Shared types and constants for the front-end fetch/decode sequencer.
package fdseq_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_ISSUE   = 3'd3,
      S_WAIT_BR = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0]  OP_JAL   = 7'b1101111;
   localparam logic [6:0]  OP_JALR  = 7'b1100111;
   localparam logic [6:0]  OP_BR    = 7'b1100011;
   localparam logic [11:0] ILL_CODE = 12'hFFF;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Control-flow instructions stall the front end until execute resolves them.
   function automatic logic is_ctrl_flow(input logic [11:0] code);
      return (code[6:0] == OP_JAL) || (code[6:0] == OP_JALR) || (code[6:0] == OP_BR);
   endfunction

endpackage

// File: rtl/fetch_decode_seq_if.sv
// Bus bundle between the sequencer and memory, decoder, execute and trap logic.
interface fdseq_if #(parameter int ADDR_W = 32);

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic [31:0]       dec_inst;
   logic [11:0]       dec_code;
   logic              iss_valid;
   logic              iss_ready;
   logic [ADDR_W-1:0] iss_pc;
   logic [11:0]       iss_code;
   logic              br_done;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              trap;
   logic [ADDR_W-1:0] trap_pc;
   logic              trap_ack;

   // Issue handshake: a transfer happens on a rising edge where iss_valid and
   // iss_ready are both 1; iss_valid never drops and iss_pc/iss_code never change
   // while iss_valid=1 and iss_ready=0. mem_req/mem_addr likewise hold until mem_ack.
   modport master (
      output mem_req, mem_addr, dec_inst, iss_valid, iss_pc, iss_code, trap, trap_pc,
      input  mem_ack, mem_rdata, dec_code, iss_ready, br_done, br_taken, br_target, trap_ack
   );

   modport slave (
      input  mem_req, mem_addr, dec_inst, iss_valid, iss_pc, iss_code, trap, trap_pc,
      output mem_ack, mem_rdata, dec_code, iss_ready, br_done, br_taken, br_target, trap_ack
   );

endinterface

// File: rtl/fetch_decode_seq.sv
// In-order front-end sequencer: fetch one word, wait for the decoder's code,
// issue or trap, and serialise control flow. Owns the PC.
module fetch_decode_seq
   import fdseq_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter logic [11:0]        ILL_CODE = fdseq_pkg::ILL_CODE
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          run,
   fdseq_if.master       bus,
   output state_t        dbg_state
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                mem_req_q, mem_req_d;
   logic [31:0]         dec_inst_q, dec_inst_d;
   logic                dec_wait_q, dec_wait_d;
   logic                iss_valid_q, iss_valid_d;
   logic [ADDR_W-1:0]   iss_pc_q, iss_pc_d;
   logic [11:0]         iss_code_q, iss_code_d;
   logic                trap_q, trap_d;
   logic [ADDR_W-1:0]   trap_pc_q, trap_pc_d;

   logic                retire;
   logic [ADDR_W-1:0]   next_pc;
   logic [ADDR_W-1:0]   pc_plus4;

   assign pc_plus4 = pc_q + ADDR_W'(4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      mem_req_d   = mem_req_q;
      dec_inst_d  = dec_inst_q;
      dec_wait_d  = dec_wait_q;
      iss_valid_d = iss_valid_q;
      iss_pc_d    = iss_pc_q;
      iss_code_d  = iss_code_q;
      trap_d      = trap_q;
      trap_pc_d   = trap_pc_q;
      retire      = 1'b0;
      next_pc     = pc_plus4;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d   = S_FETCH;
               mem_req_d = 1'b1;
            end
         end
         S_FETCH: begin
            if (bus.mem_ack) begin
               dec_inst_d = bus.mem_rdata;
               mem_req_d  = 1'b0;
               dec_wait_d = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            // First cycle lets the decoder register the new word; the code is
            // read on the following cycle.
            if (dec_wait_q) begin
               dec_wait_d = 1'b0;
            end else if (bus.dec_code == ILL_CODE) begin
               trap_d    = 1'b1;
               trap_pc_d = pc_q;
               state_d   = S_TRAP;
            end else begin
               iss_valid_d = 1'b1;
               iss_pc_d    = pc_q;
               iss_code_d  = bus.dec_code;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.iss_ready) begin
               iss_valid_d = 1'b0;
               if (is_ctrl_flow(iss_code_q)) begin
                  state_d = S_WAIT_BR;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         S_WAIT_BR: begin
            if (bus.br_done) begin
               retire = 1'b1;
               if (bus.br_taken) begin
                  next_pc = {bus.br_target[ADDR_W-1:2], 2'b00};
               end
            end
         end
         S_TRAP: begin
            if (bus.trap_ack) begin
               trap_d = 1'b0;
               retire = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // run is only consulted here, at the instruction boundary.
      if (retire) begin
         pc_d = next_pc;
         if (run) begin
            state_d   = S_FETCH;
            mem_req_d = 1'b1;
         end else begin
            state_d   = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         mem_req_q   <= 1'b0;
         dec_inst_q  <= NOP_INST;
         dec_wait_q  <= 1'b0;
         iss_valid_q <= 1'b0;
         iss_pc_q    <= RESET_PC;
         iss_code_q  <= '0;
         trap_q      <= 1'b0;
         trap_pc_q   <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         mem_req_q   <= mem_req_d;
         dec_inst_q  <= dec_inst_d;
         dec_wait_q  <= dec_wait_d;
         iss_valid_q <= iss_valid_d;
         iss_pc_q    <= iss_pc_d;
         iss_code_q  <= iss_code_d;
         trap_q      <= trap_d;
         trap_pc_q   <= trap_pc_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = pc_q;
   assign bus.dec_inst  = dec_inst_q;
   assign bus.iss_valid = iss_valid_q;
   assign bus.iss_pc    = iss_pc_q;
   assign bus.iss_code  = iss_code_q;
   assign bus.trap      = trap_q;
   assign bus.trap_pc   = trap_pc_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Randomised bench for fetch_decode_seq with an instruction-level PC model and a decoder stand-in.
module tb_fetch_decode_seq;
   import fdseq_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        run;
   state_t      dbg_state;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model_pc;

   always #5 clk = ~clk;

   fdseq_if #(.ADDR_W(32)) bus ();

   fetch_decode_seq #(.ADDR_W(32), .RESET_PC(32'h0), .ILL_CODE(12'hFFF)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .run       (run),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Decoder stand-in: registered code is the low 12 bits of the instruction.
   always @(posedge clk) bus.dec_code <= bus.dec_inst[11:0];

   function automatic bit ref_illegal(input logic [31:0] inst);
      return inst[11:0] == 12'hFFF;
   endfunction

   function automatic bit ref_ctrl(input logic [31:0] inst);
      return inst[6:0] == 7'h6F || inst[6:0] == 7'h67 || inst[6:0] == 7'h63;
   endfunction

   task automatic do_fetch(input logic [31:0] inst, input int dly);
      int i;
      i = 0;
      while (bus.mem_req !== 1'b1 && i < 40) begin
         @(negedge clk);
         i++;
      end
      n_tests++;
      if (bus.mem_req !== 1'b1) begin
         n_fail++; $display("FAIL fetch_req_timeout: got mem_req=%b want 1", bus.mem_req);
      end
      n_tests++;
      if (bus.mem_addr !== model_pc) begin
         n_fail++; $display("FAIL fetch_addr: got %h want %h", bus.mem_addr, model_pc);
      end
      repeat (dly) @(negedge clk);
      n_tests++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== model_pc) begin
         n_fail++; $display("FAIL fetch_hold: got req=%b addr=%h want req=1 addr=%h", bus.mem_req, bus.mem_addr, model_pc);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = inst;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      n_tests++;
      if (bus.mem_req !== 1'b0 || bus.dec_inst !== inst) begin
         n_fail++; $display("FAIL fetch_capture: got req=%b inst=%h want req=0 inst=%h", bus.mem_req, bus.dec_inst, inst);
      end
      @(negedge clk);
      n_tests++;
      if (bus.iss_valid !== 1'b0 || bus.trap !== 1'b0) begin
         n_fail++; $display("FAIL decode_wait: got valid=%b trap=%b want 0 0", bus.iss_valid, bus.trap);
      end
      @(negedge clk);
   endtask

   task automatic check_outcome(input logic [31:0] inst);
      n_tests++;
      if (ref_illegal(inst)) begin
         if (bus.trap !== 1'b1 || bus.trap_pc !== model_pc || bus.iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL trap_raise: got trap=%b pc=%h valid=%b want 1 %h 0", bus.trap, bus.trap_pc, bus.iss_valid, model_pc);
         end
      end else begin
         if (bus.iss_valid !== 1'b1 || bus.iss_pc !== model_pc || bus.iss_code !== inst[11:0] || bus.trap !== 1'b0) begin
            n_fail++; $display("FAIL issue: got v=%b pc=%h code=%h want 1 %h %h", bus.iss_valid, bus.iss_pc, bus.iss_code, model_pc, inst[11:0]);
         end
      end
   endtask

   task automatic retire_issue(input logic [31:0] inst, input int stall, input bit taken,
                               input logic [31:0] target, input int brdly);
      for (int s = 0; s < stall; s++) begin
         bus.br_done   = 1'(($urandom_range(0, 1)));
         bus.br_taken  = 1'b1;
         bus.br_target = $urandom;
         @(negedge clk);
         n_tests++;
         if (bus.iss_valid !== 1'b1 || bus.iss_pc !== model_pc || bus.iss_code !== inst[11:0] || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL issue_stall: got v=%b pc=%h code=%h req=%b want 1 %h %h 0", bus.iss_valid, bus.iss_pc, bus.iss_code, bus.mem_req, model_pc, inst[11:0]);
         end
      end
      bus.br_done   = 1'b0;
      bus.iss_ready = 1'b1;
      @(negedge clk);
      bus.iss_ready = 1'b0;
      n_tests++;
      if (bus.iss_valid !== 1'b0) begin
         n_fail++; $display("FAIL issue_drop: got valid=%b want 0", bus.iss_valid);
      end
      if (ref_ctrl(inst)) begin
         for (int b = 0; b < brdly; b++) begin
            n_tests++;
            if (bus.mem_req !== 1'b0) begin
               n_fail++; $display("FAIL wait_br_nofetch: got mem_req=%b want 0", bus.mem_req);
            end
            @(negedge clk);
         end
         bus.br_done   = 1'b1;
         bus.br_taken  = taken;
         bus.br_target = target;
         @(negedge clk);
         bus.br_done   = 1'b0;
         bus.br_taken  = 1'b0;
         model_pc = taken ? (target & 32'hFFFF_FFFC) : model_pc + 32'd4;
      end else begin
         model_pc = model_pc + 32'd4;
      end
   endtask

   task automatic handle_trap(input int dly);
      for (int s = 0; s < dly; s++) begin
         @(negedge clk);
         n_tests++;
         if (bus.trap !== 1'b1 || bus.iss_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL trap_hold: got trap=%b valid=%b req=%b want 1 0 0", bus.trap, bus.iss_valid, bus.mem_req);
         end
      end
      bus.trap_ack = 1'b1;
      @(negedge clk);
      bus.trap_ack = 1'b0;
      n_tests++;
      if (bus.trap !== 1'b0) begin
         n_fail++; $display("FAIL trap_clear: got trap=%b want 0", bus.trap);
      end
      model_pc = model_pc + 32'd4;
   endtask

   task automatic run_inst(input logic [31:0] inst, input int fdly, input int stall,
                           input bit taken, input logic [31:0] target, input int brdly);
      do_fetch(inst, fdly);
      check_outcome(inst);
      if (ref_illegal(inst)) handle_trap(stall);
      else retire_issue(inst, stall, taken, target, brdly);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      run  = 1'b0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.iss_ready = 1'b0;
      bus.br_done = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0; bus.trap_ack = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.dec_inst !== 32'h13) begin
         n_fail++; $display("FAIL reset_fetch: got req=%b addr=%h inst=%h want 0 0 00000013", bus.mem_req, bus.mem_addr, bus.dec_inst);
      end
      n_tests++;
      if (bus.iss_valid !== 1'b0 || bus.iss_pc !== 32'h0 || bus.iss_code !== 12'h0) begin
         n_fail++; $display("FAIL reset_issue: got v=%b pc=%h code=%h want 0 0 0", bus.iss_valid, bus.iss_pc, bus.iss_code);
      end
      n_tests++;
      if (bus.trap !== 1'b0 || bus.trap_pc !== 32'h0) begin
         n_fail++; $display("FAIL reset_trap: got trap=%b pc=%h want 0 0", bus.trap, bus.trap_pc);
      end
      rstn = 1'b1;
      model_pc = 32'h0;
   endtask

   task automatic test_basic();
      run = 1'b1;
      run_inst(32'h0050_0093, 2, 0, 1'b0, 32'h0, 0);
   endtask

   task automatic test_stall();
      run_inst(32'h0050_0093, 0, 5, 1'b0, 32'h0, 0);
   endtask

   task automatic test_jal();
      run_inst(32'h0080_006F, 1, 1, 1'b1, 32'h40, 3);
      run_inst(32'h0080_006F, 0, 0, 1'b1, 32'h0B, 2);
      run_inst(32'h0080_006F, 0, 0, 1'b0, 32'h80, 1);
      run_inst(32'h0010_0113, 0, 0, 1'b0, 32'h0, 0);
   endtask

   task automatic test_trap();
      run_inst(32'hFFFF_FFFF, 1, 3, 1'b0, 32'h0, 0);
      do_fetch(32'h0000_0013, 0);
      check_outcome(32'h0000_0013);
      retire_issue(32'h0000_0013, 0, 1'b0, 32'h0, 0);
   endtask

   task automatic test_wrap();
      run_inst(32'h0000_0063, 0, 0, 1'b1, 32'hFFFF_FFFF, 0);
      run_inst(32'h0000_0013, 0, 2, 1'b0, 32'h0, 0);
      do_fetch(32'h0000_0013, 0);
      retire_issue(32'h0000_0013, 0, 1'b0, 32'h0, 0);
   endtask

   task automatic test_run_idle();
      do_fetch(32'h0030_0193, 0);
      check_outcome(32'h0030_0193);
      run = 1'b0;
      retire_issue(32'h0030_0193, 1, 1'b0, 32'h0, 0);
      for (int s = 0; s < 4; s++) begin
         n_tests++;
         if (bus.mem_req !== 1'b0 || bus.mem_addr !== model_pc) begin
            n_fail++; $display("FAIL run_idle: got req=%b addr=%h want 0 %h", bus.mem_req, bus.mem_addr, model_pc);
         end
         @(negedge clk);
      end
      run = 1'b1;
      run_inst(32'h0000_0013, 0, 0, 1'b0, 32'h0, 0);
   endtask

   task automatic test_random();
      logic [31:0] r, inst, tgt;
      int kind;
      for (int n = 0; n < 40; n++) begin
         r    = $urandom;
         kind = $urandom_range(0, 9);
         if (kind < 6)      inst = {r[31:7], 7'b0010011};
         else if (kind < 8) inst = {r[31:7], (kind == 6) ? 7'b1100011 : ((r[0]) ? 7'b1101111 : 7'b1100111)};
         else               inst = {r[31:12], 12'hFFF};
         tgt = $urandom;
         run_inst(inst, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), tgt, $urandom_range(0, 3));
      end
   endtask

   task automatic test_reset_mid();
      int i;
      i = 0;
      while (bus.mem_req !== 1'b1 && i < 40) begin
         @(negedge clk);
         i++;
      end
      #2;
      rstn = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      #1;
      n_tests++;
      if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
         n_fail++; $display("FAIL reset_async: got req=%b addr=%h want 0 0", bus.mem_req, bus.mem_addr);
      end
      @(negedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      rstn = 1'b1;
      model_pc = 32'h0;
      @(negedge clk);
      n_tests++;
      if (bus.dec_inst !== 32'h13 || bus.mem_req !== 1'b1) begin
         n_fail++; $display("FAIL reset_stale_ack: got inst=%h req=%b want 00000013 1", bus.dec_inst, bus.mem_req);
      end
      run_inst(32'h0050_0093, 1, 0, 1'b0, 32'h0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_jal();
      test_trap();
      test_wrap();
      test_run_idle();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_decode_seq.md
Name: fetch_decode_seq

Overview:
- Sequencer for the in-order core front end.
- Fetches one instruction word over a req/ack memory port and holds it stable on the decoder's instruction input.
- Waits one cycle for the decoder's registered opcode class, then issues it to execute over a valid/ready handshake.
- Serialises control flow (waits for branch/jump resolution), traps illegal encodings, and owns the PC.

Parameters:
- ADDR_W, 32, PC / memory address width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- ILL_CODE, 12'hFFF, decoder code value meaning illegal instruction.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- run  in  1  level; 1 allows fetching, 0 parks the sequencer in IDLE after the current instruction retires.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_addr  out  ADDR_W  fetch address (= pc); stable while mem_req=1.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  32  fetched instruction word.
- dec_inst  out  32  instruction to decoder; registered.
- dec_code  in  12  decoder registered code; valid one clk after dec_inst changes.
- iss_valid  out  1  issue valid.
- iss_ready  in  1  execute accepts.
- iss_pc  out  ADDR_W  PC of the issued instruction.
- iss_code  out  12  dec_code captured for issue.
- br_done  in  1  execute resolved the outstanding control-flow instruction.
- br_taken  in  1  qualified by br_done; 1 means redirect.
- br_target  in  ADDR_W  redirect PC, qualified by br_done and br_taken.
- trap  out  1  illegal-instruction trap pending.
- trap_pc  out  ADDR_W  PC of the offending instruction.
- trap_ack  in  1  trap handled; sequencer resumes at pc+4.

Behaviour:
- Reset (rstn=0, async):
  - state=IDLE, pc=RESET_PC.
  - mem_req=0, mem_addr=RESET_PC.
  - dec_inst=32'h0000_0013 (addi x0,x0,0).
  - iss_valid=0, iss_pc=RESET_PC, iss_code=0.
  - trap=0, trap_pc=RESET_PC.
  - Reset mid-handshake drops the request; no pending ack is honoured after release.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_BR, TRAP.
- IDLE: run=1 -> FETCH with mem_req=1, mem_addr=pc.
- FETCH: mem_req=1 until mem_ack. On mem_ack, dec_inst<=mem_rdata, mem_req<=0 next cycle, -> DECODE.
- DECODE: exactly one cycle so the decoder registers the code. Next cycle, classify dec_code:
  - dec_code==ILL_CODE -> TRAP: trap=1, trap_pc=pc.
  - otherwise -> ISSUE: iss_valid=1, iss_pc=pc, iss_code=dec_code.
- ISSUE:
  - iss_valid, iss_pc and iss_code are held stable until iss_ready.
  - On iss_valid&iss_ready: if iss_code[6:0] is 1101111 (jal), 1100111 (jalr) or 1100011 (branch) -> WAIT_BR.
  - Otherwise pc<=pc+4, then FETCH if run=1, else IDLE.
  - iss_valid drops the cycle after the handshake.
- WAIT_BR: no fetch. On br_done: pc<=br_taken ? br_target : pc+4, then FETCH if run=1, else IDLE. br_done in any other state is ignored.
- TRAP: trap stays 1 until trap_ack. On trap_ack: trap<=0, pc<=pc+4, then FETCH if run, else IDLE.
- Throughput and latency:
  - Minimum fetch-to-issue latency is mem_ack cycle +2 (DECODE, then iss_valid).
  - No fetch overlap; one instruction in flight.
- PC arithmetic: modulo 2^ADDR_W; pc+4 wraps at the address-space top without error. br_target[1:0] is forced to 00.
- run deassertion is sampled only at instruction boundaries; it never aborts FETCH, ISSUE, WAIT_BR or TRAP.
- Decoder shares clk. The sequencer does not drive the decoder's register file index outputs; execute takes those directly.

Decomposition:
- Shared package fdseq_pkg holds:
  - state enum;
  - opcode constants OP_JAL=7'b1101111, OP_JALR=7'b1100111, OP_BR=7'b1100011;
  - ILL_CODE;
  - NOP_INST=32'h0000_0013.
- A single module is sufficient; no sub-module.

Test Plan:
- Reset then run=1, mem_ack at cycle 3 with 32'h00500093 (addi x1,x0,5) -> mem_addr=0, iss_valid two cycles after ack, iss_pc=0, iss_code=12'h093; iss_ready=1 -> next mem_addr=4.
- Hold iss_ready=0 for 5 cycles -> iss_valid, iss_pc and iss_code remain constant; no mem_req asserted.
- Fetch jal (32'h0080006F) at pc=8 and issue -> no mem_req until br_done. Then:
  - br_done=1, br_taken=1, br_target=32'h40 -> mem_addr=32'h40.
  - Repeat with br_taken=0 -> mem_addr=12.
- Fetch 32'hFFFFFFFF at pc=16 -> decoder code FFF, trap=1, trap_pc=16, iss_valid never asserted. trap_ack -> mem_addr=20.
- pc=32'hFFFF_FFFC, issue non-branch -> next mem_addr=0.
- Assert rstn=0 while mem_req=1 awaiting ack -> mem_req=0 immediately (async). After release, the first fetch is at RESET_PC, and a stale mem_ack during reset is ignored.
